bist_misr_compactor: RTL and testbench

- Serial-input response compactor and signature checker. It sits directly downstream of the scan chain's serial output in the BIST path.
- Compacts the CUT scan-out stream (cut_sdo) into a WIDTH-bit MISR signature and counts the compacted bits.
- At session end it compares the signature and bit count against the stored golden values, then reports done/pass to the BIST controller.
- It can optionally learn the golden signature from a known-good run.

---
 rtl/bist_misr_compactor.sv | 136 +++++++++++++
 tb/tb_bist_misr_compactor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bist_misr_compactor.sv
// Serial-input MISR response compactor with bit counter and golden-signature check.
// Compacts scan-out bits during RUN and reports done/pass after a single CHECK cycle.
module bist_misr_compactor #(
  parameter int              WIDTH         = 16,
  parameter logic [WIDTH-1:0] POLY         = 16'h1021,
  parameter logic [WIDTH-1:0] SEED         = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN       = 16'h0000,
  parameter int              EXPECTED_BITS = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             sdo_bit,
  input  logic             end_session,
  input  logic             learn,
  output logic [WIDTH-1:0] signature,
  output logic [31:0]      bit_count,
  output logic             sig_valid,
  output logic             pass,
  output logic             stray_bit
);

  localparam logic [31:0] EXP_CNT = 32'(EXPECTED_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             pass_q, pass_d;
  logic             stray_q, stray_d;
  logic             learn_q, learn_d;
  logic [WIDTH-1:0] misr_next;

  // Galois MISR step with the serial bit folded in at bit 0
  assign misr_next = {sig_q[WIDTH-2:0], 1'b0}
                   ^ (sig_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                   ^ {{(WIDTH-1){1'b0}}, sdo_bit};

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    golden_d = golden_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    pass_d   = pass_q;
    stray_d  = stray_q;
    learn_d  = learn_q;

    if (en && (state_q != RUN)) begin
      stray_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = 32'd0;
          valid_d = 1'b0;
          pass_d  = 1'b0;
          stray_d = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = 32'd0;
          valid_d = 1'b0;
          pass_d  = 1'b0;
          stray_d = 1'b0;
        end else begin
          if (en) begin
            sig_d = misr_next;
            if (cnt_q != 32'hFFFF_FFFF) begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          if (end_session) begin
            state_d = CHECK;
            learn_d = learn;
          end
        end
      end
      CHECK: begin
        // A learn run adopts the current signature, so only the count decides pass
        if (learn_q) begin
          golden_d = sig_q;
          pass_d   = (cnt_q == EXP_CNT);
        end else begin
          pass_d   = (sig_q == golden_q) && (cnt_q == EXP_CNT);
        end
        valid_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      golden_q <= GOLDEN;
      cnt_q    <= 32'd0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      stray_q  <= 1'b0;
      learn_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      stray_q  <= stray_d;
      learn_q  <= learn_d;
    end
  end

  assign signature = sig_q;
  assign bit_count = cnt_q;
  assign sig_valid = valid_q;
  assign pass      = pass_q;
  assign stray_bit = stray_q;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Directed bench: a 17-bit-session instance for hand-computed signatures and a
// default-parameter instance for the 2000-bit LFSR-driven run; both share stimulus.
module tb_bist_misr_compactor;

  logic        clk = 1'b0;
  logic        rst, start, en, sdo_bit, end_session, learn;
  logic [15:0] sig_a, sig_b;
  logic [31:0] cnt_a, cnt_b;
  logic        valid_a, valid_b, pass_a, pass_b, stray_a, stray_b;

  int vectors = 0;
  int miscompares = 0;

  logic stream [0:1999];

  always #5 clk = ~clk;

  bist_misr_compactor #(.EXPECTED_BITS(17)) dut_a (
    .clk(clk), .rst(rst), .start(start), .en(en), .sdo_bit(sdo_bit),
    .end_session(end_session), .learn(learn),
    .signature(sig_a), .bit_count(cnt_a), .sig_valid(valid_a),
    .pass(pass_a), .stray_bit(stray_a)
  );

  bist_misr_compactor dut_b (
    .clk(clk), .rst(rst), .start(start), .en(en), .sdo_bit(sdo_bit),
    .end_session(end_session), .learn(learn),
    .signature(sig_b), .bit_count(cnt_b), .sig_valid(valid_b),
    .pass(pass_b), .stray_bit(stray_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference serial MISR step, written from the Galois update equation
  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic b);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ b;
    return r;
  endfunction

  // Start pulse, n bits with end_session on the last one, then wait out CHECK
  task automatic applyStimulus(input int n, input logic lrn);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      en          = 1'b1;
      sdo_bit     = stream[i];
      end_session = (i == n - 1);
      learn       = lrn;
      tick();
    end
    en          = 1'b0;
    sdo_bit     = 1'b0;
    end_session = 1'b0;
    learn       = 1'b0;
  endtask

  task automatic load_impulse(input int n, input logic first);
    for (int i = 0; i < 2000; i++) stream[i] = 1'b0;
    stream[0] = first;
  endtask

  initial begin
    logic [15:0] lfsr;
    logic [15:0] exp_sig;

    rst = 1'b1; start = 1'b0; en = 1'b0; sdo_bit = 1'b0;
    end_session = 1'b0; learn = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("reset_sig", {16'h0, sig_a}, 32'h0);
    checkOutput("reset_cnt", cnt_a, 32'd0);
    checkOutput("reset_valid", {31'h0, valid_a}, 32'd0);
    checkOutput("reset_pass", {31'h0, pass_a}, 32'd0);
    checkOutput("reset_stray", {31'h0, stray_a}, 32'd0);

    en = 1'b1; sdo_bit = 1'b1;
    tick(); tick();
    en = 1'b0; sdo_bit = 1'b0;
    checkOutput("idle_stray", {31'h0, stray_a}, 32'd1);
    checkOutput("idle_sig", {16'h0, sig_a}, 32'h0);
    checkOutput("idle_cnt", cnt_a, 32'd0);

    // Learn run: impulse followed by 16 zeros yields the polynomial itself
    load_impulse(17, 1'b1);
    applyStimulus(17, 1'b1);
    checkOutput("learn_stray_cleared", {31'h0, stray_a}, 32'd0);
    checkOutput("learn_valid_early", {31'h0, valid_a}, 32'd0);
    tick();
    checkOutput("learn_valid", {31'h0, valid_a}, 32'd1);
    checkOutput("learn_sig", {16'h0, sig_a}, 32'h1021);
    checkOutput("learn_cnt", cnt_a, 32'd17);
    checkOutput("learn_pass", {31'h0, pass_a}, 32'd1);

    en = 1'b1; sdo_bit = 1'b1;
    tick();
    en = 1'b0; sdo_bit = 1'b0;
    checkOutput("done_stray", {31'h0, stray_a}, 32'd1);
    checkOutput("done_sig_held", {16'h0, sig_a}, 32'h1021);
    checkOutput("done_cnt_held", cnt_a, 32'd17);
    checkOutput("done_valid_held", {31'h0, valid_a}, 32'd1);

    applyStimulus(17, 1'b0);
    tick();
    checkOutput("cmp_stray_cleared", {31'h0, stray_a}, 32'd0);
    checkOutput("cmp_pass", {31'h0, pass_a}, 32'd1);

    load_impulse(17, 1'b0);
    applyStimulus(17, 1'b0);
    tick();
    checkOutput("zeros_sig", {16'h0, sig_a}, 32'h0);
    checkOutput("zeros_pass", {31'h0, pass_a}, 32'd0);

    load_impulse(16, 1'b1);
    applyStimulus(16, 1'b0);
    tick();
    checkOutput("short_sig", {16'h0, sig_a}, 32'h8000);
    checkOutput("short_cnt", cnt_a, 32'd16);
    checkOutput("short_pass", {31'h0, pass_a}, 32'd0);

    // Abort: five stray-looking bits in RUN are discarded by the restart
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; sdo_bit = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0; sdo_bit = 1'b0;
    checkOutput("abort_partial_cnt", cnt_a, 32'd5);
    load_impulse(17, 1'b1);
    applyStimulus(17, 1'b0);
    tick();
    checkOutput("abort_cnt", cnt_a, 32'd17);
    checkOutput("abort_sig", {16'h0, sig_a}, 32'h1021);
    checkOutput("abort_pass", {31'h0, pass_a}, 32'd1);

    // Reset mid-RUN restores seed and the parameter golden (0x0000)
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; sdo_bit = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b0; sdo_bit = 1'b0;
    checkOutput("midrst_sig", {16'h0, sig_a}, 32'h0);
    checkOutput("midrst_cnt", cnt_a, 32'd0);
    checkOutput("midrst_valid", {31'h0, valid_a}, 32'd0);
    end_session = 1'b1; tick(); end_session = 1'b0;
    tick(); tick();
    checkOutput("idle_endsess_ignored", {31'h0, valid_a}, 32'd0);
    load_impulse(17, 1'b0);
    applyStimulus(17, 1'b0);
    tick();
    checkOutput("golden_reset_pass", {31'h0, pass_a}, 32'd1);

    // 2000-bit run on the default-parameter instance
    lfsr = 16'hACE1;
    exp_sig = 16'h0000;
    for (int i = 0; i < 2000; i++) begin
      stream[i] = lfsr[0];
      exp_sig = misr_model(exp_sig, lfsr[0]);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    applyStimulus(2000, 1'b1);
    tick();
    checkOutput("long_learn_sig", {16'h0, sig_b}, {16'h0, exp_sig});
    checkOutput("long_learn_cnt", cnt_b, 32'd2000);
    checkOutput("long_learn_valid", {31'h0, valid_b}, 32'd1);
    checkOutput("long_learn_pass", {31'h0, pass_b}, 32'd1);

    applyStimulus(2000, 1'b0);
    tick();
    checkOutput("long_cmp_pass", {31'h0, pass_b}, 32'd1);

    stream[1000] = ~stream[1000];
    exp_sig = 16'h0000;
    for (int i = 0; i < 2000; i++) exp_sig = misr_model(exp_sig, stream[i]);
    applyStimulus(2000, 1'b0);
    tick();
    checkOutput("long_flip_sig", {16'h0, sig_b}, {16'h0, exp_sig});
    checkOutput("long_flip_pass", {31'h0, pass_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
